serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 1, bits added per clock cycle.
REQ-003 Legal parameters SHALL be DIGIT >= 1, DIGIT <= WIDTH and WIDTH mod DIGIT == 0; K = WIDTH/DIGIT SHALL denote the number of digit cycles.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-006 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port start, input, 1, request a new operation.
REQ-008 The block SHALL have port sub, input, 1, 0 = add, 1 = subtract.
REQ-009 The block SHALL have port a, input, WIDTH, operand A.
REQ-010 The block SHALL have port b, input, WIDTH, operand B.
REQ-011 The block SHALL have port ci, input, 1, carry-in (add) or borrow-in (subtract).
REQ-012 The block SHALL have port busy, output, 1, operation in progress.
REQ-013 The block SHALL have port done, output, 1, one-cycle result-valid pulse.
REQ-014 The block SHALL have port s, output, WIDTH, registered result.
REQ-015 The block SHALL have port co, output, 1, carry-out (add) or not-borrow (subtract).
REQ-016 The block SHALL have port ovf, output, 1, two's-complement signed overflow.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and DONE; IDLE SHALL be the reset state.
REQ-018 start SHALL be accepted on a rising edge only when busy=0 (IDLE or DONE state); at acceptance a, b, sub and ci SHALL be captured into internal registers.
REQ-019 start while busy=1 SHALL be ignored, with no effect on the operation in progress or on captured operands.
REQ-020 Add SHALL compute {co,s} = a + b + ci, modulo 2^(WIDTH+1).
REQ-021 Subtract SHALL compute a + ~b + ~ci, i.e. s = a - b - ci mod 2^WIDTH, co = 1 when no borrow occurred.
REQ-022 Each RUN cycle SHALL add one DIGIT-bit slice, LSB slice first, through a DIGIT-bit ripple of full-adder cells, with the carry held in a 1-bit register between cycles.
REQ-023 busy SHALL be 1 from the edge accepting start through exactly K clock cycles.
REQ-024 On the K-th edge after acceptance, s, co and ovf SHALL update, busy SHALL fall, and done SHALL be 1 for exactly one cycle (DONE state).
REQ-025 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-026 s, co and ovf SHALL hold their values until the next completed operation; they SHALL not show partial results during RUN.
REQ-027 From DONE, the FSM SHALL go to RUN if start=1, otherwise to IDLE; a back-to-back start SHALL give done pulses exactly K+1 cycles apart... no idle cycle beyond DONE.
REQ-028 When DIGIT = WIDTH (K=1), the block SHALL produce done one cycle after acceptance with busy high for one cycle.
REQ-029 Input changes on a, b, sub or ci after acceptance SHALL not affect the result.

Reset
REQ-030 With rst=1 at a rising edge, the FSM SHALL enter IDLE and set busy=0, done=0, s=0, co=0, ovf=0 and the carry register to 0.
REQ-031 rst SHALL take priority over start; reset during RUN SHALL abort the operation with no done pulse.
REQ-032 The first start accepted after rst deasserts SHALL behave identically to one after power-up.

Verification
REQ-033 WIDTH=8, DIGIT=1, add 8'hFF + 8'h01, ci=0 -> after 8 cycles s=8'h00, co=1, ovf=0, done pulses once.
REQ-034 WIDTH=8, DIGIT=1, add 8'h7F + 8'h01, ci=0 -> s=8'h80, co=0, ovf=1.
REQ-035 WIDTH=8, DIGIT=1, sub 8'h05 - 8'h07, ci=0 -> s=8'hFE, co=0, ovf=0; sub 8'h80 - 8'h01, ci=0 -> s=8'h7F, co=1, ovf=1.
REQ-036 WIDTH=8, DIGIT=4, add 8'h3C + 8'hC4, ci=1 -> busy high 2 cycles, s=8'h01, co=1; start asserted during busy is ignored.
REQ-037 rst asserted in cycle 3 of an 8-cycle RUN -> next cycle busy=0, done never pulses, s/co/ovf=0; subsequent start completes normally.
REQ-038 Back-to-back starts asserted in the DONE cycle -> second operation accepted, done pulses K+1 cycles apart, each with the correct result.

Source files
------------

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock, LSB digit first,
// and publishes sum, carry-out and signed overflow after WIDTH/DIGIT cycles.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int K  = WIDTH / DIGIT;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [DIGIT-1:0] sum_dig;
  logic [DIGIT:0]   c;

  // One digit of ripple-carry full adders fed from the low end of the operand shifters
  assign c[0] = carry_q;
  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
    assign sum_dig[gi] = a_q[gi] ^ b_q[gi] ^ c[gi];
    assign c[gi+1]     = (a_q[gi] & b_q[gi]) | (c[gi] & (a_q[gi] ^ b_q[gi]));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    carry_d = carry_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          // Subtraction is a + ~b + ~ci, so invert at capture time
          state_d = RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~ci : ci;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = WIDTH'({sum_dig, acc_q} >> DIGIT);
        carry_d = c[DIGIT];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          s_d     = acc_d;
          co_d    = c[DIGIT];
          ovf_d   = c[DIGIT] ^ c[DIGIT-1];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: a bit-serial (DIGIT=1) and a 4-bit-digit
// instance share operand inputs but have separate start strobes.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start4;
  logic       sub;
  logic [7:0] a, b;
  logic       ci;

  logic       busy1, done1, co1, ovf1;
  logic [7:0] s1;
  logic       busy4, done4, co4, ovf4;
  logic [7:0] s4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub), .a(a), .b(b), .ci(ci),
    .busy(busy1), .done(done1), .s(s1), .co(co1), .ovf(ovf1)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a), .b(b), .ci(ci),
    .busy(busy4), .done(done4), .s(s4), .co(co4), .ovf(ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Drive a request at the current negedge, release after the accepting edge,
  // then scramble the operand inputs so late changes would corrupt a bad design.
  task automatic launch(input bit four, input logic sb, input logic [7:0] aa,
                        input logic [7:0] bb, input logic cc);
    sub = sb; a = aa; b = bb; ci = cc;
    if (four) start4 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    sub = ~sb; a = ~aa; b = ~bb ^ 8'h5A; ci = ~cc;
  endtask

  task automatic wait_done(input bit four, output int n);
    n = 0;
    while (((four ? done4 : done1) !== 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic check_result(input bit four, input string tag, input logic [7:0] es,
                              input logic ec, input logic eo);
    chk({tag, "_s"},   four ? s4 : s1, 32'(es));
    chk({tag, "_co"},  four ? co4 : co1, 32'(ec));
    chk({tag, "_ovf"}, four ? ovf4 : ovf1, 32'(eo));
    chk({tag, "_busy_low"}, four ? busy4 : busy1, 32'd0);
  endtask

  // Complete operation on the bit-serial instance: latency 8, one-cycle done
  task automatic op1(input string tag, input logic sb, input logic [7:0] aa,
                     input logic [7:0] bb, input logic cc, input logic [7:0] es,
                     input logic ec, input logic eo);
    int n;
    launch(1'b0, sb, aa, bb, cc);
    chk({tag, "_busy"}, busy1, 32'd1);
    wait_done(1'b0, n);
    chk({tag, "_latency"}, n, 32'd8);
    check_result(1'b0, tag, es, ec, eo);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, done1, 32'd0);
  endtask

  initial begin
    int  n;
    bit  seen;
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
    sub = 1'b0; a = 8'h00; b = 8'h00; ci = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy1", busy1, 32'd0);
    chk("rst_done1", done1, 32'd0);
    chk("rst_s1",    s1,    32'd0);
    chk("rst_co1",   co1,   32'd0);
    chk("rst_ovf1",  ovf1,  32'd0);
    chk("rst_busy4", busy4, 32'd0);
    chk("rst_s4",    s4,    32'd0);
    rst = 1'b0;
    @(negedge clk);

    op1("add_ff_01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op1("add_7f_01", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    op1("add_ci",    1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
    op1("sub_05_07", 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
    op1("sub_bin",   1'b1, 8'h10, 8'h01, 1'b1, 8'h0E, 1'b1, 1'b0);
    op1("sub_80_01", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);

    // 4-bit digits: two busy cycles; a start during busy must be ignored
    launch(1'b1, 1'b0, 8'h3C, 8'hC4, 1'b1);
    chk("d4_busy", busy4, 32'd1);
    start4 = 1'b1; a = 8'hFF; b = 8'hFF; sub = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_done(1'b1, n);
    chk("d4_latency", n + 1, 32'd2);
    check_result(1'b1, "d4_add", 8'h01, 1'b1, 1'b0);
    @(negedge clk);
    chk("d4_idle_after", busy4, 32'd0);

    // Reset in the third RUN cycle aborts; outputs clear and no done appears
    launch(1'b0, 1'b0, 8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy1, 32'd0);
    chk("abort_s",    s1,    32'd0);
    chk("abort_co",   co1,   32'd0);
    chk("abort_ovf",  ovf1,  32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done1 === 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    op1("post_rst", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    // Back-to-back: second start in the DONE cycle, done pulses K+1 apart
    launch(1'b0, 1'b0, 8'hA5, 8'h5A, 1'b0);
    wait_done(1'b0, n);
    chk("b2b_first_latency", n, 32'd8);
    check_result(1'b0, "b2b_first", 8'hFF, 1'b0, 1'b0);
    launch(1'b0, 1'b1, 8'h03, 8'h04, 1'b0);
    chk("b2b_busy", busy1, 32'd1);
    wait_done(1'b0, n);
    chk("b2b_spacing", n + 1, 32'd9);
    check_result(1'b0, "b2b_second", 8'hFF, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
